// File: rtl/stream_select_mux.sv
// N-channel registered stream selector with valid/ready handshake, fixed-select or round-robin mode.
// Optional 1-entry skid register behind the output when SELECT_MUX_SKID_EN is defined.
module stream_select_mux #(
    parameter int WIDTH    = 17,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic [CHANNELS*WIDTH-1:0] InData,
    input  logic [CHANNELS-1:0]       InValid,
    output logic [CHANNELS-1:0]       InReady,
    input  logic [SEL_W-1:0]          Selection,
    output logic [WIDTH-1:0]          OutData,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [SEL_W-1:0]          Grant
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick;
    logic             pick_ok;
    logic [WIDTH-1:0] pick_data;
    logic             open;
    logic             transfer;
    int               scan;

`ifdef SELECT_MUX_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_grant;
`endif

    // Choose the candidate channel: Selection in fixed mode, first valid from ptr in round-robin.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        scan    = 0;
        if (MODE == 1) begin
            for (int i = 0; i < CHANNELS; i++) begin
                scan = int'(ptr) + i;
                if (scan >= CHANNELS) begin
                    scan = scan - CHANNELS;
                end
                if (!pick_ok && InValid[SEL_W'(scan)]) begin
                    pick    = SEL_W'(scan);
                    pick_ok = 1'b1;
                end
            end
        end else begin
            pick    = Selection;
            pick_ok = (int'(Selection) < CHANNELS);
        end
    end

    always_comb begin
        pick_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (SEL_W'(k) == pick) begin
                pick_data = InData[k*WIDTH +: WIDTH];
            end
        end
    end

    // The skid build keeps OutReady out of the InReady cone entirely.
    always_comb begin
`ifdef SELECT_MUX_SKID_EN
        open = !skid_valid;
`else
        open = !OutValid || OutReady;
`endif
        for (int k = 0; k < CHANNELS; k++) begin
            InReady[k] = Reset_n && pick_ok && open && (SEL_W'(k) == pick);
        end
        transfer = |(InReady & InValid);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            OutValid   <= 1'b0;
            OutData    <= '0;
            Grant      <= '0;
            ptr        <= '0;
`ifdef SELECT_MUX_SKID_EN
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_grant <= '0;
`endif
        end else begin
            if (transfer) begin
                ptr <= (int'(pick) == CHANNELS - 1) ? '0 : pick + 1'b1;
            end
`ifdef SELECT_MUX_SKID_EN
            if (OutValid && !OutReady) begin
                if (transfer) begin
                    skid_valid <= 1'b1;
                    skid_data  <= pick_data;
                    skid_grant <= pick;
                end
            end else if (skid_valid) begin
                OutData    <= skid_data;
                Grant      <= skid_grant;
                OutValid   <= 1'b1;
                skid_valid <= 1'b0;
            end else if (transfer) begin
                OutData  <= pick_data;
                Grant    <= pick;
                OutValid <= 1'b1;
            end else begin
                OutValid <= 1'b0;
            end
`else
            if (transfer) begin
                OutData  <= pick_data;
                Grant    <= pick;
                OutValid <= 1'b1;
            end else if (OutReady) begin
                OutValid <= 1'b0;
            end
`endif
        end
    end

endmodule
